// File: rtl/mem_port_arbiter_if.sv
// Memory port bus: fetch and data requester handshakes,
// the shared memory command channel and the PC stall.
interface mem_port_arbiter_if #(
  parameter int N = 64
);
  logic         if_req;
  logic [N-1:0] if_addr;
  logic         if_ack;
  logic [31:0]  if_rdata;

  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic         d_ack;
  logic [N-1:0] d_rdata;

  logic         mem_valid;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ready;
  logic [N-1:0] mem_rdata;

  logic         stall;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output stall
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store.
// Data wins arbitration; a grant counter keeps fetch from starving.
module mem_port_arbiter #(
  parameter int N     = 64,
  parameter int MAX_D = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  localparam logic [3:0] MAX_C = 4'(MAX_D);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         if_ack_q, if_ack_d;
  logic         d_ack_q, d_ack_d;
  logic [31:0]  if_rdata_q, if_rdata_d;
  logic [N-1:0] d_rdata_q, d_rdata_d;
  logic         arb_ok;
  logic         starve;

  // The ack cycle is dead for arbitration: it gives the requester
  // one cycle to drop or renew its request.
  assign arb_ok = ~(if_ack_q | d_ack_q);
  assign starve = (cnt_q == MAX_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_ok) begin
          if (bus.if_req && (!bus.d_req || starve)) begin
            state_d = BUSY_I;
            valid_d = 1'b1;
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wdata_d = '0;
            cnt_d   = '0;
          end else if (bus.d_req) begin
            state_d = BUSY_D;
            valid_d = 1'b1;
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            if (!bus.if_req)
              cnt_d = '0;
            else if (!starve)
              cnt_d = cnt_q + 4'd1;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          valid_d    = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_rdata[31:0];
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          d_ack_d = 1'b1;
          if (!we_q)
            d_rdata_d = bus.mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.stall = (bus.if_req & ~if_ack_q)
                   | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority,
// wait-state store, starvation, reset mid-access, stray ready.
module tb_mem_port_arbiter;

  localparam int N = 64;

  logic clk;
  logic reset;
  int   errs;
  int   chks;

  mem_port_arbiter_if #(.N(N)) bus ();

  mem_port_arbiter #(.N(N), .MAX_D(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] ld0;
  logic [7:0]  seq [6];

  initial begin
    errs = 0;
    chks = 0;
    seq[0] = "D"; seq[1] = "D"; seq[2] = "D";
    seq[3] = "D"; seq[4] = "I"; seq[5] = "D";
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    chk("rst_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_addr", bus.mem_addr, 64'd0);
    chk("rst_ifack", 64'(bus.if_ack), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    reset = 1'b1;
    tick();

    // Fetch, memory always ready
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'hD2800020;
    #1;
    chk("f_stall0", 64'(bus.stall), 64'd1);
    tick();
    chk("f_valid", 64'(bus.mem_valid), 64'd1);
    chk("f_addr", bus.mem_addr, 64'h100);
    chk("f_we", 64'(bus.mem_we), 64'd0);
    chk("f_stall1", 64'(bus.stall), 64'd1);
    chk("f_ack0", 64'(bus.if_ack), 64'd0);
    tick();
    chk("f_ack", 64'(bus.if_ack), 64'd1);
    chk("f_rdata", 64'(bus.if_rdata), 64'hD2800020);
    chk("f_valid_off", 64'(bus.mem_valid), 64'd0);
    chk("f_stall2", 64'(bus.stall), 64'd0);
    tick();
    bus.if_req = 1'b0;
    chk("f_ack_off", 64'(bus.if_ack), 64'd0);
    chk("f_no_regrant", 64'(bus.mem_valid), 64'd0);

    // Simultaneous fetch + load: data first, acks 3 apart
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h200;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 64'h2000;
    ld0           = 64'h1122334455667788;
    bus.mem_rdata = ld0;
    tick();
    chk("p_addr_d", bus.mem_addr, 64'h2000);
    chk("p_valid", 64'(bus.mem_valid), 64'd1);
    tick();
    bus.mem_rdata = 64'h13000013;
    chk("p_dack", 64'(bus.d_ack), 64'd1);
    chk("p_drdata", bus.d_rdata, ld0);
    chk("p_ifack0", 64'(bus.if_ack), 64'd0);
    tick();
    bus.d_req = 1'b0;
    chk("p_dack_off", 64'(bus.d_ack), 64'd0);
    chk("p_gap", 64'(bus.mem_valid), 64'd0);
    tick();
    chk("p_addr_i", bus.mem_addr, 64'h200);
    chk("p_ifack1", 64'(bus.if_ack), 64'd0);
    tick();
    chk("p_ifack", 64'(bus.if_ack), 64'd1);
    chk("p_ifrdata", 64'(bus.if_rdata), 64'h13000013);
    chk("p_drdata_keep", bus.d_rdata, ld0);
    tick();
    bus.if_req = 1'b0;

    // Store with three wait states
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 64'h18;
    bus.d_wdata   = 64'hDEADBEEF;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 64'h5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.mem_ready = 1'b1;
      chk("s_valid", 64'(bus.mem_valid), 64'd1);
      chk("s_we", 64'(bus.mem_we), 64'd1);
      chk("s_addr", bus.mem_addr, 64'h18);
      chk("s_wdata", bus.mem_wdata, 64'hDEADBEEF);
      chk("s_ack_wait", 64'(bus.d_ack), 64'd0);
      chk("s_stall", 64'(bus.stall), 64'd1);
    end
    tick();
    chk("s_ack", 64'(bus.d_ack), 64'd1);
    chk("s_valid_off", 64'(bus.mem_valid), 64'd0);
    chk("s_rdata_keep", bus.d_rdata, ld0);
    tick();
    bus.d_req = 1'b0;
    chk("s_ack_pulse", 64'(bus.d_ack), 64'd0);

    // Starvation guard: 4 data grants then 1 fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h300;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'h4000;
    for (int t = 0; t < 18; t++) begin
      tick();
      if (t % 3 == 0) begin
        chk("v_valid", 64'(bus.mem_valid), 64'd1);
        chk("v_grant",
            (bus.mem_addr == 64'h4000) ? 64'h44 : 64'h49,
            64'(seq[t / 3]));
      end else if (t % 3 == 2) begin
        chk("v_gap", 64'(bus.mem_valid), 64'd0);
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();

    // Reset in the middle of a stalled load
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 64'h5000;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("r_busy", 64'(bus.mem_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("r_valid", 64'(bus.mem_valid), 64'd0);
    chk("r_addr", bus.mem_addr, 64'd0);
    chk("r_drdata", bus.d_rdata, 64'd0);
    chk("r_ifrdata", 64'(bus.if_rdata), 64'd0);
    chk("r_stall", 64'(bus.stall), 64'd1);
    bus.d_req     = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h600;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h00000013;
    tick();
    chk("r_hold", 64'(bus.mem_valid), 64'd0);
    chk("r_no_dack", 64'(bus.d_ack), 64'd0);
    reset = 1'b1;
    tick();
    chk("r_grant", bus.mem_addr, 64'h600);
    chk("r_no_dack2", 64'(bus.d_ack), 64'd0);
    tick();
    chk("r_ifack", 64'(bus.if_ack), 64'd1);
    chk("r_dack_none", 64'(bus.d_ack), 64'd0);
    tick();
    bus.if_req = 1'b0;

    // Stray ready while idle
    bus.mem_ready = 1'b1;
    tick();
    chk("i_valid", 64'(bus.mem_valid), 64'd0);
    chk("i_ifack", 64'(bus.if_ack), 64'd0);
    chk("i_dack", 64'(bus.d_ack), 64'd0);
    bus.mem_ready = 1'b0;
    tick();
    chk("i_valid2", 64'(bus.mem_valid), 64'd0);
    chk("i_dack2", 64'(bus.d_ack), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single memory port between instruction fetch and data load/store. It sequences each access with a request/ready handshake, returns read data per requester, and drives a stall that holds the PC flopr while a transaction is outstanding. Data accesses have priority, and a counter keeps fetch from starving.

## Interface
- N, 64, address/data width
- MAX_D, 4, max consecutive data grants while a fetch is pending (range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  N  fetch address; stable while if_req
- if_ack  out  1  one-cycle pulse, fetch complete
- if_rdata  out  32  fetched instruction, mem_rdata[31:0]
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  N  data address
- d_wdata  in  N  store data
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  N  load data
- mem_valid  out  1  memory transaction active
- mem_we  out  1  write enable to memory
- mem_addr  out  N  memory address
- mem_wdata  out  N  memory write data
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  N  memory read data, valid when mem_ready
- stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack); holds the PC register

## Operation
- States:
  - IDLE: mem_valid = 0.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
- Arbitration happens in IDLE on each clk edge. A requester whose ack is high this cycle is ignored.
- The grant goes to data if d_req is set, unless the starvation rule applies.
- Starvation rule: if d_cnt == MAX_D and if_req is set, the grant goes to fetch.
- With only if_req set, the grant goes to fetch.
- On grant, the command is latched into mem_addr, mem_we and mem_wdata, and mem_valid is set next cycle. A fetch grant forces mem_we = 0 and mem_wdata = 0.
- The latched command stays constant until completion. Requester inputs are not re-sampled while BUSY.
- BUSY_x with mem_ready = 1 does the following, then returns to IDLE:
  - Read: mem_rdata is registered into if_rdata or d_rdata.
  - Ack: the matching ack pulses high for the next cycle.
  - mem_valid drops next cycle.
- BUSY_x with mem_ready = 0 stays in the state with the command unchanged. There is no timeout.
- A store leaves d_rdata unchanged.
- d_cnt (4-bit, saturating at MAX_D):
  - +1 on a data grant while if_req is set.
  - Cleared on any fetch grant.
  - Cleared on a data grant while if_req = 0.
- mem_ready seen while in IDLE is ignored.
- Asynchronous reset (reset = 0), whether idle or mid-transaction:
  - State goes to IDLE and d_cnt to 0.
  - All outputs go to 0: mem_valid, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata.
  - Any in-flight transaction is abandoned and no ack is issued.
  - stall follows its equation, with acks at 0.

## Timing
- Request sampled at edge k: mem_valid is high during cycle k+1.
- Ready at edge m (first edge with mem_valid & mem_ready): ack is high and rdata valid during cycle m+1, and mem_valid is low in m+1.
- Minimum request-to-ack latency is 2 cycles (mem_ready tied high).
- Back-to-back throughput is one transaction per 3 cycles: IDLE, BUSY, ack/IDLE.
- Requesters drop req, or present a new request, in the cycle after ack. That new request is sampled one edge later.
- All outputs except stall are registered. stall is combinational.
- Reset release is synchronous to clk; the first arbitration happens on the first edge with reset = 1.

## Test plan
- Reset, then if_req with if_addr = 0x100, mem_ready tied 1, mem_rdata = 0xD2800020 → mem_valid one cycle with addr 0x100 and we = 0. if_ack pulses 2 cycles after the request with if_rdata = 0xD2800020. stall is high until the ack cycle.
- if_req and d_req asserted together for a load at 0x2000 → data is served first and d_ack precedes if_ack by 3 cycles. d_rdata = mem_rdata of the first transaction.
- Store with d_addr = 0x18, d_wdata = 0xDEADBEEF, mem_ready delayed 3 cycles → mem_we = 1 and addr/wdata are stable for 4 cycles. d_ack is a single pulse and d_rdata is unchanged.
- if_req held continuously, d_req re-asserted after every ack, MAX_D = 4 → exactly 4 data grants, then 1 fetch grant, then the cycle repeats.
- Reset asserted during BUSY_D with mem_ready = 0 → all outputs are 0 immediately and no d_ack appears. After release, a pending if_req is granted normally.
- mem_ready pulsed while IDLE → no ack and no state change.
